// File: rtl/cam_pkg.sv
// Shared types and defaults for the OV7670 frame capture sequencer.
package cam_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } cam_state_e;

  localparam int H_BYTES_DEF = 320;  // 160 px x 2 bytes
  localparam int V_LINES_DEF = 120;

  // OV7670 default polarities: Vsync high during blanking, Href high on valid bytes
  localparam logic VSYNC_BLANK = 1'b1;
  localparam logic HREF_ACTIVE = 1'b1;

endpackage

// File: rtl/cam_sync_edge.sv
// Single-register edge detector; rise/fall are combinational against the registered copy.
module cam_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);

  always_ff @(posedge clk) begin
    if (rst) q <= 1'b0;
    else     q <= din;
  end

  assign rise = ~q & din;
  assign fall = q & ~din;

endmodule

// File: rtl/cam_capture_ctrl.sv
// Frame-level sequencer for the OV7670 capture path (Pclk domain).
// Optional geometry checking is built when CAM_GEOM_CHECK_EN is defined.
module cam_capture_ctrl
  import cam_pkg::*;
#(
  parameter int H_BYTES = H_BYTES_DEF,
  parameter int V_LINES = V_LINES_DEF,
  parameter int TMO_W   = 20,
  parameter int FCNT_W  = 8
) (
  input  logic              Pclk,
  input  logic              rst,
  input  logic              Vsync,
  input  logic              Href,
  input  logic              start,
  input  logic              continuous,
  input  logic              stop,
  output logic              cap_en,
  output logic              addr_clr,
  output logic              busy,
  output logic              frame_done,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic [7:0]        line_cnt,
  output logic              err_timeout,
  output logic              err_geom
);

  cam_state_e       state, state_nxt;
  logic             cont_q, stop_pend, tmo_hit;
  logic [TMO_W-1:0] tmo;

  // Normalise polarity so the FSM sees "in blanking" and "byte valid"
  logic vs_blank, hr_act;
  assign vs_blank = (Vsync == VSYNC_BLANK);
  assign hr_act   = (Href == HREF_ACTIVE);

  logic vs_q, vs_rise, vs_fall;
  logic hr_q, hr_rise_unused, hr_fall;

  cam_sync_edge u_vs_edge (
    .clk  (Pclk),
    .rst  (rst),
    .din  (vs_blank),
    .q    (vs_q),
    .rise (vs_rise),
    .fall (vs_fall)
  );

  cam_sync_edge u_hr_edge (
    .clk  (Pclk),
    .rst  (rst),
    .din  (hr_act),
    .q    (hr_q),
    .rise (hr_rise_unused),
    .fall (hr_fall)
  );

  logic stop_now;
  assign stop_now = stop | stop_pend;

  always_comb begin
    state_nxt = state;
    tmo_hit   = 1'b0;
    case (state)
      IDLE:    if (start) state_nxt = WAIT_VS;
      WAIT_VS: begin
        if (vs_fall)       state_nxt = CAPTURE;
        else if (stop_now) state_nxt = IDLE;
        else if (&tmo) begin
          state_nxt = IDLE;
          tmo_hit   = 1'b1;
        end
      end
      CAPTURE: if (vs_rise) state_nxt = DONE;
      DONE:    state_nxt = (cont_q && !stop_now) ? WAIT_VS : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register
  always_ff @(posedge Pclk) begin
    if (rst) begin
      state       <= IDLE;
      cont_q      <= 1'b0;
      stop_pend   <= 1'b0;
      tmo         <= '0;
      cap_en      <= 1'b0;
      addr_clr    <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_cnt   <= '0;
      line_cnt    <= '0;
      err_timeout <= 1'b0;
    end else begin
      state      <= state_nxt;
      cap_en     <= (state_nxt == CAPTURE);
      busy       <= (state_nxt != IDLE);
      frame_done <= (state_nxt == DONE);
      addr_clr   <= (state == WAIT_VS) && (state_nxt == CAPTURE);

      if (state == IDLE && start) begin
        cont_q      <= continuous;
        frame_cnt   <= '0;
        err_timeout <= 1'b0;
        tmo         <= '0;
      end
      if (state == WAIT_VS) tmo <= tmo + 1'b1;
      if (state == DONE)    tmo <= '0;
      if (tmo_hit)          err_timeout <= 1'b1;

      if (state == CAPTURE && state_nxt == DONE) frame_cnt <= frame_cnt + 1'b1;

      if (state_nxt == IDLE)            stop_pend <= 1'b0;
      else if (stop && state != IDLE)   stop_pend <= 1'b1;

      if (state == WAIT_VS && vs_fall)
        line_cnt <= '0;
      else if (state == CAPTURE && hr_fall && line_cnt != 8'hFF)
        line_cnt <= line_cnt + 1'b1;
    end
  end

`ifdef CAM_GEOM_CHECK_EN
  logic [8:0] byte_cnt;

  always_ff @(posedge Pclk) begin
    if (rst) begin
      byte_cnt <= '0;
      err_geom <= 1'b0;
    end else begin
      if (state == IDLE && start) err_geom <= 1'b0;
      if (state == WAIT_VS && vs_fall) begin
        byte_cnt <= '0;
      end else if (state == CAPTURE) begin
        // hr_fall implies Href already low, so the line total is final here
        if (hr_fall) begin
          if (int'(byte_cnt) != H_BYTES) err_geom <= 1'b1;
          byte_cnt <= '0;
        end else if (hr_act) begin
          byte_cnt <= byte_cnt + 1'b1;
        end
        if (vs_rise && int'(line_cnt) != V_LINES) err_geom <= 1'b1;
      end
    end
  end
`else
  localparam int GEOM_UNUSED = H_BYTES + V_LINES;
  assign err_geom = 1'b0;
`endif

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Directed bench for cam_capture_ctrl: a cycle-by-cycle vector table plus frame-level sequences.
module tb_cam_capture_ctrl;

  localparam int FCNT_W = 8;

  logic Pclk = 1'b0;
  logic rst = 1'b1, Vsync = 1'b1, Href = 1'b0;
  logic start = 1'b0, continuous = 1'b0, stop = 1'b0;
  logic cap_en, addr_clr, busy, frame_done, err_timeout, err_geom;
  logic [FCNT_W-1:0] frame_cnt;
  logic [7:0] line_cnt;

  int checks = 0, errors = 0;
  int n_done = 0, n_cap = 0, n_clr = 0;

`ifdef CAM_GEOM_CHECK_EN
  localparam logic GEOM_EXP = 1'b1;
`else
  localparam logic GEOM_EXP = 1'b0;
`endif

  cam_capture_ctrl #(
    .H_BYTES(320), .V_LINES(120), .TMO_W(6), .FCNT_W(FCNT_W)
  ) dut (
    .Pclk(Pclk), .rst(rst), .Vsync(Vsync), .Href(Href),
    .start(start), .continuous(continuous), .stop(stop),
    .cap_en(cap_en), .addr_clr(addr_clr), .busy(busy), .frame_done(frame_done),
    .frame_cnt(frame_cnt), .line_cnt(line_cnt),
    .err_timeout(err_timeout), .err_geom(err_geom)
  );

  always #5 Pclk = ~Pclk;

  always @(negedge Pclk) begin
    if (frame_done) n_done <= n_done + 1;
    if (cap_en)     n_cap  <= n_cap + 1;
    if (addr_clr)   n_clr  <= n_clr + 1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  typedef struct {
    logic [4:0] in;   // {Vsync, Href, start, continuous, stop}
    logic [3:0] out;  // {busy, cap_en, addr_clr, frame_done}
    logic [7:0] line;
    logic [7:0] fcnt;
  } vec_t;

  vec_t tv[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge Pclk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; Vsync = 1'b1; Href = 1'b0; start = 1'b0; stop = 1'b0; continuous = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic pulse_start(input logic cont);
    continuous = cont; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Vsync falls, nl lines of nb Href-high cycles with 2-cycle gaps, Vsync rises, 4 blanking cycles
  task automatic frame(input int nl, input int nb, input int stop_l, input logic exp_cap);
    Vsync = 1'b0;
    tick();
    chk("addr_clr_at_vs_fall", addr_clr, exp_cap);
    chk("cap_en_after_vs_fall", cap_en, exp_cap);
    tick();
    chk("addr_clr_one_cycle", addr_clr, 0);
    for (int l = 0; l < nl; l++) begin
      if (l == stop_l) begin stop = 1'b1; tick(); stop = 1'b0; end
      Href = 1'b1;
      repeat (nb) tick();
      Href = 1'b0;
      repeat (2) tick();
    end
    chk("cap_en_before_vs_rise", cap_en, exp_cap);
    Vsync = 1'b1;
    tick();
    chk("frame_done_at_vs_rise", frame_done, exp_cap);
    chk("cap_en_off_at_done", cap_en, 0);
    repeat (4) tick();
  endtask

  initial begin
    int d0, c0, k0, n;

    tv[0]  = '{5'b10000, 4'b0000, 8'd0, 8'd0};
    tv[1]  = '{5'b00000, 4'b0000, 8'd0, 8'd0};  // vs_fall while idle
    tv[2]  = '{5'b10000, 4'b0000, 8'd0, 8'd0};
    tv[3]  = '{5'b00100, 4'b1000, 8'd0, 8'd0};  // start and vs_fall together
    tv[4]  = '{5'b00000, 4'b1000, 8'd0, 8'd0};
    tv[5]  = '{5'b01000, 4'b1000, 8'd0, 8'd0};
    tv[6]  = '{5'b00000, 4'b1000, 8'd0, 8'd0};  // hr_fall outside capture
    tv[7]  = '{5'b10000, 4'b1000, 8'd0, 8'd0};
    tv[8]  = '{5'b00000, 4'b1110, 8'd0, 8'd0};  // vs_fall -> capture
    tv[9]  = '{5'b01000, 4'b1100, 8'd0, 8'd0};
    tv[10] = '{5'b01000, 4'b1100, 8'd0, 8'd0};
    tv[11] = '{5'b00000, 4'b1100, 8'd1, 8'd0};
    tv[12] = '{5'b01000, 4'b1100, 8'd1, 8'd0};
    tv[13] = '{5'b00000, 4'b1100, 8'd2, 8'd0};
    tv[14] = '{5'b10000, 4'b1001, 8'd2, 8'd1};  // vs_rise -> done
    tv[15] = '{5'b10000, 4'b0000, 8'd2, 8'd1};
    tv[16] = '{5'b10001, 4'b0000, 8'd2, 8'd1};  // stop while idle
    tv[17] = '{5'b10100, 4'b1000, 8'd2, 8'd0};
    tv[18] = '{5'b10001, 4'b0000, 8'd2, 8'd0};  // stop from WAIT_VS
    tv[19] = '{5'b00000, 4'b0000, 8'd2, 8'd0};

    // Reset state
    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_cap_en", cap_en, 0);
    chk("rst_addr_clr", addr_clr, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_line_cnt", line_cnt, 0);
    chk("rst_err_timeout", err_timeout, 0);
    chk("rst_err_geom", err_geom, 0);

    // Cycle-level vectors
    for (int i = 0; i < 20; i++) begin
      {Vsync, Href, start, continuous, stop} = tv[i].in;
      tick();
      chk($sformatf("vec%0d_busy", i),       busy,       tv[i].out[3]);
      chk($sformatf("vec%0d_cap_en", i),     cap_en,     tv[i].out[2]);
      chk($sformatf("vec%0d_addr_clr", i),   addr_clr,   tv[i].out[1]);
      chk($sformatf("vec%0d_frame_done", i), frame_done, tv[i].out[0]);
      chk($sformatf("vec%0d_line_cnt", i),   line_cnt,   tv[i].line);
      chk($sformatf("vec%0d_frame_cnt", i),  frame_cnt,  tv[i].fcnt);
    end
    start = 1'b0; stop = 1'b0;

    // Full single frame, 120 x 320
    do_reset();
    pulse_start(1'b0);
    d0 = n_done; c0 = n_cap; k0 = n_clr;
    frame(120, 320, -1, 1'b1);
    chk("full_done_pulses", n_done - d0, 1);
    chk("full_clr_pulses", n_clr - k0, 1);
    chk("full_cap_cycles", n_cap - c0, 2 + 120 * 322);
    chk("full_frame_cnt", frame_cnt, 1);
    chk("full_line_cnt", line_cnt, 120);
    chk("full_busy", busy, 0);
    chk("full_err_timeout", err_timeout, 0);
    chk("full_err_geom", err_geom, 0);

    // Continuous, stop during third frame
    do_reset();
    pulse_start(1'b1);
    d0 = n_done;
    frame(3, 16, -1, 1'b1);
    frame(3, 16, -1, 1'b1);
    frame(3, 16, 1, 1'b1);
    chk("cont_done_pulses", n_done - d0, 3);
    chk("cont_frame_cnt", frame_cnt, 3);
    chk("cont_busy_after_stop", busy, 0);
    c0 = n_cap;
    frame(3, 16, -1, 1'b0);
    chk("cont_no_cap_after_stop", n_cap - c0, 0);
    chk("cont_frame_cnt_hold", frame_cnt, 3);

    // Arm mid-frame: nothing until the next vs_fall
    do_reset();
    Vsync = 1'b0;
    repeat (3) tick();
    Href = 1'b1; repeat (5) tick(); Href = 1'b0; tick();
    c0 = n_cap; k0 = n_clr; d0 = n_done;
    pulse_start(1'b0);
    chk("mid_busy", busy, 1);
    repeat (2) begin Href = 1'b1; repeat (5) tick(); Href = 1'b0; repeat (2) tick(); end
    Vsync = 1'b1;
    repeat (4) tick();
    chk("mid_no_cap_partial", n_cap - c0, 0);
    chk("mid_no_clr_partial", n_clr - k0, 0);
    frame(3, 10, -1, 1'b1);
    chk("mid_clr_total", n_clr - k0, 1);
    chk("mid_done_total", n_done - d0, 1);
    chk("mid_line_cnt", line_cnt, 3);

    // Timeout with Vsync stuck high
    do_reset();
    pulse_start(1'b0);
    n = 0;
    while (busy && n < 200) begin tick(); n++; end
    chk("tmo_cycles", n, 64);
    chk("tmo_err", err_timeout, 1);
    chk("tmo_idle", busy, 0);
    pulse_start(1'b0);
    chk("tmo_err_cleared", err_timeout, 0);
    chk("tmo_rearmed", busy, 1);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("tmo_stop_idle", busy, 0);
    chk("tmo_stop_no_err", err_timeout, 0);

    // Geometry: short frame (2 lines), then a 318-byte line
    do_reset();
    pulse_start(1'b0);
    d0 = n_done;
    frame(2, 320, -1, 1'b1);
    chk("geom_lines_err", err_geom, GEOM_EXP);
    chk("geom_lines_done", n_done - d0, 1);
    pulse_start(1'b0);
    chk("geom_err_cleared", err_geom, 0);
    Vsync = 1'b0; tick(); tick();
    Href = 1'b1; repeat (318) tick(); Href = 1'b0;
    tick(); tick();
    chk("geom_bytes_err", err_geom, GEOM_EXP);
    Vsync = 1'b1; tick();
    chk("geom_bytes_done", frame_done, 1);
    repeat (3) tick();

    // Reset in the middle of capture
    do_reset();
    pulse_start(1'b0);
    Vsync = 1'b0; tick();
    Href = 1'b1; repeat (8) tick(); Href = 1'b0; repeat (2) tick();
    chk("rstcap_cap_before", cap_en, 1);
    chk("rstcap_line_before", line_cnt, 1);
    d0 = n_done;
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rstcap_cap_en", cap_en, 0);
    chk("rstcap_busy", busy, 0);
    chk("rstcap_frame_done", frame_done, 0);
    chk("rstcap_frame_cnt", frame_cnt, 0);
    chk("rstcap_line_cnt", line_cnt, 0);
    Vsync = 1'b1;
    repeat (4) tick();
    chk("rstcap_no_done", n_done - d0, 0);
    chk("rstcap_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
